// File: rtl/mem_arbiter.sv
// mem_arbiter: IF/LS arbiter for one single-ported memory with watchdog; MEM_ARB_RR_EN selects round-robin grant
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_wen,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_done,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                tmo_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);
  state_t            state;
  logic              owner;
  logic [15:0]       cnt;
  logic              grant_ls;
  logic              tmo;
  logic              fin;
  logic              st;
  logic [DATA_W-1:0] fin_data;
`ifdef MEM_ARB_RR_EN
  logic last_owner;
  always_comb grant_ls = ls_req & (~if_req | ~last_owner);
`else
  always_comb grant_ls = ls_req;
`endif
  always_comb begin
    tmo      = (state == REQ || state == WAIT) && cnt == TMO_LAST;
    fin      = tmo || (state == WAIT && mem_rvalid);
    fin_data = (tmo || mem_wen) ? '0 : mem_rdata;
    st       = grant_ls & ls_wen;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      cnt       <= '0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      tmo_err   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner <= 1'b0;
`endif
    end else begin
      if_done <= fin & ~owner;
      ls_done <= fin & owner;
      if (fin & ~owner) if_rdata <= fin_data;
      if (fin & owner) ls_rdata <= fin_data;
      if (tmo) tmo_err <= 1'b1;
      case (state)
        IDLE: if (if_req | ls_req) begin
          state     <= REQ;
          owner     <= grant_ls;
          cnt       <= '0;
          mem_req   <= 1'b1;
          mem_wen   <= st;
          mem_addr  <= grant_ls ? ls_addr : if_addr;
          mem_wdata <= st ? ls_wdata : '0;
          mem_wmask <= st ? ls_wmask : '0;
`ifdef MEM_ARB_RR_EN
          last_owner <= grant_ls;
`endif
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (tmo) begin
            state   <= RESP;
            mem_req <= 1'b0;
          end else if (mem_ready) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (fin) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (TMO_CYCLES=8)
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_wen, mem_ready, mem_rvalid;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_wmask;
  logic        if_done, ls_done, mem_req, mem_wen, tmo_err;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  int          total = 0;
  int          passed = 0;
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TMO_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .tmo_err(tmo_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else passed++;
  endtask
  initial begin
    rst = 1; if_req = 0; ls_req = 0; ls_wen = 0; mem_ready = 0; mem_rvalid = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0; ls_wmask = 0;
    tick; tick;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_tmo", tmo_err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    rst = 0;
    // single fetch
    if_req = 1; if_addr = 32'h8000_0000; mem_ready = 1;
    tick;
    chk("f_req", mem_req, 1);
    chk("f_addr", mem_addr, 32'h8000_0000);
    chk("f_wen", mem_wen, 0);
    chk("f_wmask", mem_wmask, 0);
    tick;
    chk("f_req_drop", mem_req, 0);
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0413;
    tick;
    chk("f_done", if_done, 1);
    chk("f_rdata", if_rdata, 32'h0000_0413);
    chk("f_ls_done", ls_done, 0);
    if_req = 0; mem_rvalid = 0;
    tick;
    chk("f_done_pulse", if_done, 0);
    // store
    ls_req = 1; ls_wen = 1; ls_addr = 32'h8000_1004; ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'h3;
    tick;
    chk("s_req", mem_req, 1);
    chk("s_wen", mem_wen, 1);
    chk("s_wmask", mem_wmask, 4'h3);
    chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s_addr", mem_addr, 32'h8000_1004);
    mem_ready = 1;
    tick;
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    tick;
    chk("s_done", ls_done, 1);
    chk("s_rdata", ls_rdata, 0);
    chk("s_if_done", if_done, 0);
    ls_req = 0; ls_wen = 0; mem_rvalid = 0;
    tick;
    // contention: LS first, then IF after a bubble
    if_req = 1; if_addr = 32'h100; ls_req = 1; ls_addr = 32'h200;
    tick;
    chk("c_ls_addr", mem_addr, 32'h200);
    chk("c_ls_wen", mem_wen, 0);
    mem_ready = 1;
    tick;
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA_AAAA;
    tick;
    chk("c_ls_done", ls_done, 1);
    chk("c_ls_rdata", ls_rdata, 32'hAAAA_AAAA);
    chk("c_if_wait", if_done, 0);
    ls_req = 0; mem_rvalid = 0;
    tick;
    chk("c_bubble", mem_req, 0);
    tick;
    chk("c_if_req", mem_req, 1);
    chk("c_if_addr", mem_addr, 32'h100);
    mem_ready = 1;
    tick;
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h5555_5555;
    tick;
    chk("c_if_done", if_done, 1);
    chk("c_if_rdata", if_rdata, 32'h5555_5555);
    if_req = 0; mem_rvalid = 0;
    tick;
    // backpressure with a stray rvalid during REQ
    if_req = 1; if_addr = 32'h300;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("b_req", mem_req, 1);
      chk("b_addr", mem_addr, 32'h300);
      mem_rvalid = (i == 2);
      mem_rdata = 32'hBAD0_0000;
      tick;
    end
    mem_rvalid = 0; mem_ready = 1;
    tick;
    chk("b_wait_req", mem_req, 0);
    chk("b_no_done", if_done, 0);
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    tick;
    chk("b_done", if_done, 1);
    chk("b_rdata", if_rdata, 32'h77);
    chk("b_tmo", tmo_err, 0);
    if_req = 0; mem_rvalid = 0;
    tick;
    // timeout: 1 REQ cycle + 7 WAIT cycles
    ls_req = 1; ls_addr = 32'h400;
    tick;
    for (int i = 0; i < 7; i++) begin
      mem_ready = (i == 0);
      tick;
    end
    mem_ready = 0;
    chk("t_pre_tmo", tmo_err, 0);
    chk("t_pre_done", ls_done, 0);
    tick;
    chk("t_tmo", tmo_err, 1);
    chk("t_done", ls_done, 1);
    chk("t_rdata", ls_rdata, 0);
    ls_req = 0;
    tick;
    chk("t_done_pulse", ls_done, 0);
    tick;
    chk("t_sticky", tmo_err, 1);
    chk("t_idle", mem_req, 0);
    // reset mid-WAIT
    if_req = 1; if_addr = 32'h500;
    tick;
    mem_ready = 1;
    tick;
    mem_ready = 0; rst = 1; if_req = 0;
    tick;
    rst = 0;
    chk("r_tmo", tmo_err, 0);
    chk("r_req", mem_req, 0);
    chk("r_addr", mem_addr, 0);
    chk("r_if_rdata", if_rdata, 0);
    chk("r_ls_rdata", ls_rdata, 0);
    mem_rvalid = 1; mem_rdata = 32'h99;
    tick;
    chk("r_no_done", if_done, 0);
    mem_rvalid = 0;
    tick;
    chk("r_still_idle", if_done, 0);
    if_req = 1; if_addr = 32'h600;
    tick;
    chk("r_next_req", mem_req, 1);
    chk("r_next_addr", mem_addr, 32'h600);
    mem_ready = 1;
    tick;
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1234;
    tick;
    chk("r_next_done", if_done, 1);
    chk("r_next_rdata", if_rdata, 32'h1234);
    if_req = 0; mem_rvalid = 0;
    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
